alu_muldiv_unit: RTL
====================

Name: alu_muldiv_unit

Overview:
- Iterative multiply/divide companion to the ALU control/ALU path. Executes the R-type funct group 16–27 (mfhi, mthi, mflo, mtlo, mult, multu, div, divu) and owns the architectural HI/LO registers.
- Parametrised in operand width.
- Uses a start/busy/done handshake and raises a stall toward the pipeline when an access hits an operation in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits; must be even and ≥4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  operation strobe, sampled on the rising edge
- funct  in  6  R-type funct field
- a  in  WIDTH  rs operand (multiplicand/dividend; source for mthi/mtlo)
- b  in  WIDTH  rt operand (multiplier/divisor)
- result  out  WIDTH  combinational; HI when funct=16, LO when funct=18, else 0
- busy  out  1  mult/div in progress
- done  out  1  one-cycle pulse, HI/LO updated
- div_by_zero  out  1  one-cycle pulse coincident with done for div/divu with b=0
- stall  out  1  combinational: start & busy
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect at any time, including mid-operation): state=IDLE; hi, lo, counter and internal registers cleared to 0; busy, done and div_by_zero = 0. Release is synchronous to the next edge.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, start=1, on edge k:
  - funct=17 (mthi): hi←a; no done.
  - funct=19 (mtlo): lo←a; no done.
  - funct=16/18: no state change.
  - funct=24/25: latch operands → MUL, counter=WIDTH.
  - funct=26/27, b≠0: latch operands → DIV, counter=WIDTH.
  - funct=26/27, b=0: → FIX with div_by_zero flag set.
  - Any other funct: ignored.
- Operand latching: signed ops (24, 26) latch magnitudes and record the result sign (product: sa^sb; quotient: sa^sb; remainder: sa). Unsigned ops latch operands as-is.
- MUL: one shift-add per edge on a 2·WIDTH accumulator; counter decrements; at counter=1 → FIX.
- DIV: one restoring shift-subtract per edge; counter decrements; at counter=1 → FIX.
- FIX, on edge k+WIDTH+1:
  - Apply two's-complement sign correction.
  - Write hi/lo: mult → hi=upper half, lo=lower half; div → lo=quotient, hi=remainder.
  - Divide-by-zero: hi/lo unchanged.
  - done=1 for exactly one cycle; → IDLE.
- Divide-by-zero path: FIX is reached at edge k+1, done at k+2.
- Latency: done rises after edge k+WIDTH+1 for mult/div (33 edges for WIDTH=32).
- busy: high from edge k to edge k+WIDTH+1; low in the done cycle. A start in the done cycle is accepted.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Overflow case MIN / −1: lo=MIN, hi=0, no flag.
- start while busy: ignored entirely (no HI/LO change, no restart); stall=1 that cycle.
- result is purely combinational from hi/lo. Readers must honour stall; during busy, result shows the pre-operation values.

Test Plan (WIDTH=32):
- mult a=0xFFFFFFFE, b=3 → done after 33 edges; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for 33 cycles.
- multu a=0xFFFFFFFE, b=3 → hi=0x00000002, lo=0xFFFFFFFA.
- div a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 → lo=3, hi=1.
- div a=5, b=0 → done 2 edges after start, div_by_zero=1, hi/lo retain prior values. div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- mtlo a=0x1234 then start funct=18 → result=0x00001234. Issue mfhi/mthi during a mult → stall=1; hi unchanged until done.
- Assert rst_n=0 at cycle 10 of a mult → busy=0, hi=lo=0 immediately without a clock edge; no done pulse follows.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Handles mfhi/mthi/mflo/mtlo/mult/multu/div/divu with a start/busy/done handshake.
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div;
    logic               r_neg_prod;
    logic               r_neg_quo;
    logic               r_neg_rem;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dz;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = ~funct[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;

    // Multiply: r_acc holds {partial product, remaining multiplier bits}.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);

    // Divide: r_acc holds {partial remainder, dividend/quotient shift register}.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opb;

    assign w_prod = r_neg_prod ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_quo ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opb      <= '0;
            r_is_div   <= 1'b0;
            r_neg_prod <= 1'b0;
            r_neg_quo  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dbz      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (funct)
                            6'd17: r_hi <= a;
                            6'd19: r_lo <= a;
                            6'd24, 6'd25: begin
                                r_acc      <= {{WIDTH{1'b0}}, w_b_mag};
                                r_opb      <= w_a_mag;
                                r_neg_prod <= w_a_neg ^ w_b_neg;
                                r_is_div   <= 1'b0;
                                r_cnt      <= CNT_W'(WIDTH);
                                r_state    <= S_MUL;
                            end
                            6'd26, 6'd27: begin
                                r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
                                r_opb     <= w_b_mag;
                                r_neg_quo <= w_a_neg ^ w_b_neg;
                                r_neg_rem <= w_a_neg;
                                r_is_div  <= 1'b1;
                                // Zero divisor spends a single throw-away step so FIX lands one edge later.
                                r_dbz     <= (b == '0);
                                r_cnt     <= (b == '0) ? CNT_W'(1) : CNT_W'(WIDTH);
                                r_state   <= S_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
                end
                S_DIV: begin
                    if (w_div_ge) r_acc <= {w_div_diff, r_acc[WIDTH-2:0], 1'b1};
                    else          r_acc <= {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    r_dz   <= r_dbz;
                    if (!r_dbz) begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                    r_dbz   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign stall       = start & busy;
    assign result      = (funct == 6'd16) ? r_hi : (funct == 6'd18) ? r_lo : '0;

endmodule
